// File: rtl/circuit_checker_pkg.sv
// circuit_checker_pkg: shared state type and sizing constants for the circuit checker
package circuit_checker_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam int NUM_VECTORS = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;
  localparam logic [15:0] GOLDEN_A010_3 = 16'hFFFF;
endpackage

// File: rtl/circuit_checker_settle_timer.sv
// settle_timer: counts cycles while enabled, tc pulses on the SETTLE_CYCLES-th enabled cycle; ports clk, rst, clr, en, tc
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 4'd1;
  assign tc = en && (cnt == 4'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/circuit_checker.sv
// circuit_checker: sweeps 16 vectors into a 4-input circuit, checks s against GOLDEN, reports pass/err_count/first_fail; CHECKER_STOP_ON_FAIL_EN ends the sweep at the first mismatch
// Ports: clk, rst (async high), start; dut_a..dut_d stimulus, dut_s response; busy, done, pass, err_count, first_fail_idx, first_fail_valid
module circuit_checker
  import circuit_checker_pkg::*;
#(
  parameter logic [15:0] GOLDEN = GOLDEN_A010_3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic dut_a,
  output logic dut_b,
  output logic dut_c,
  output logic dut_d,
  input  logic dut_s,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic first_fail_valid
);
`ifdef CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif
  state_t state;
  logic [IDX_W-1:0] idx;
  logic tc, miss;
  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state != APPLY),
    .en(state == APPLY),
    .tc(tc)
  );
  assign miss = dut_s != GOLDEN[idx];
  // idx is itself a register, so the stimulus is glitch-free and holds the last vector in DONE
  assign {dut_a, dut_b, dut_c, dut_d} = idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      // status flags are registered decodes of the state; an accepted start clears done at once
      busy <= state == APPLY || state == SAMPLE;
      done <= state == DONE && !start;
      pass <= state == DONE && !start && err_count == '0;
      case (state)
        IDLE, DONE:
          if (start) begin
            err_count <= '0;
            first_fail_idx <= '0;
            first_fail_valid <= 1'b0;
            idx <= '0;
            state <= APPLY;
          end
        APPLY: if (tc) state <= SAMPLE;
        SAMPLE: begin
          if (miss) begin
            err_count <= err_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail_idx <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          if (idx == IDX_W'(NUM_VECTORS - 1) || (STOP_ON_FAIL && miss)) state <= DONE;
          else begin
            idx <= idx + 1'b1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_circuit_checker.sv
module tb_circuit_checker;
  typedef struct {
    logic [4:0] err;
    logic [3:0] ffi;
    logic ffv;
    logic pass;
    logic [3:0] vec;
  } exp_t;
  logic clk = 0, rst = 1, start1 = 0, start2 = 0;
  logic a1, b1, c1, d1, busy1, done1, pass1, ffv1, s1;
  logic a2, b2, c2, d2, busy2, done2, pass2, ffv2;
  logic [4:0] err1, err2;
  logic [3:0] ffi1, ffi2, vec1, vec2;
  int mode = 1;
  int checks = 0, errors = 0;
  exp_t q1[$], q2[$];
  exp_t e_clean, e_zero, e_six, e_8000;
  logic dq1 = 0, dq2 = 0;
  always #5 clk = ~clk;
  assign vec1 = {a1, b1, c1, d1};
  assign vec2 = {a2, b2, c2, d2};
  assign s1 = mode == 1 ? 1'b1 : mode == 0 ? 1'b0 : (vec1 != 4'd6);
  circuit_checker #(.GOLDEN(16'hFFFF), .SETTLE_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_d(d1),
    .dut_s(s1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_idx(ffi1), .first_fail_valid(ffv1));
  circuit_checker #(.GOLDEN(16'h8000), .SETTLE_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dut_a(a2), .dut_b(b2), .dut_c(c2), .dut_d(d2),
    .dut_s(1'b1), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_idx(ffi2), .first_fail_valid(ffv2));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cmp(input string tag, input exp_t e, input logic [4:0] err, input logic [3:0] ffi,
                     input logic ffv, input logic pass, input logic [3:0] vec);
    chk({tag, ".err_count"}, 32'(err), 32'(e.err));
    chk({tag, ".first_fail_idx"}, 32'(ffi), 32'(e.ffi));
    chk({tag, ".first_fail_valid"}, 32'(ffv), 32'(e.ffv));
    chk({tag, ".pass"}, 32'(pass), 32'(e.pass));
    chk({tag, ".vector"}, 32'(vec), 32'(e.vec));
  endtask
  always @(negedge clk) begin
    if (done1 && !dq1) begin
      if (q1.size() == 0) chk("u1.unexpected_done", 1, 0);
      else cmp("u1", q1.pop_front(), err1, ffi1, ffv1, pass1, vec1);
    end
    dq1 = done1;
  end
  always @(negedge clk) begin
    if (done2 && !dq2) begin
      if (q2.size() == 0) chk("u2.unexpected_done", 1, 0);
      else cmp("u2", q2.pop_front(), err2, ffi2, ffv2, pass2, vec2);
    end
    dq2 = done2;
  end
  task automatic run(input int which, input exp_t e, input int lat, input bit inject);
    int n = 0, nb = 0;
    bit injected = 0;
    if (which == 0) q1.push_back(e); else q2.push_back(e);
    @(posedge clk); #1;
    if (which == 0) start1 = 1; else start2 = 1;
    @(posedge clk); #1;
    start1 = 0; start2 = 0;
    chk("done_low_after_start", 32'(which == 0 ? done1 : done2), 0);
    while (!(which == 0 ? done1 : done2) && n < 200) begin
      if (inject && !injected && busy1 && vec1 == 4'd3) begin
        start1 = 1;
        injected = 1;
      end
      @(posedge clk); #1;
      start1 = 0;
      n++;
      nb += int'(which == 0 ? busy1 : busy2);
    end
    if (n >= 200) chk("done_timeout", 0, 1);
    if (lat != 0) begin
      chk("latency", 32'(n), 32'(lat));
      chk("busy_cycles", 32'(nb), 32'(lat - 1));
    end
    @(posedge clk); #1;
  endtask
  initial begin
    e_clean = '{5'd0, 4'd0, 1'b0, 1'b1, 4'd15};
`ifdef CHECKER_STOP_ON_FAIL_EN
    e_zero = '{5'd1, 4'd0, 1'b1, 1'b0, 4'd0};
    e_six = '{5'd1, 4'd6, 1'b1, 1'b0, 4'd6};
    e_8000 = '{5'd1, 4'd0, 1'b1, 1'b0, 4'd0};
`else
    e_zero = '{5'd16, 4'd0, 1'b1, 1'b0, 4'd15};
    e_six = '{5'd1, 4'd6, 1'b1, 1'b0, 4'd15};
    e_8000 = '{5'd15, 4'd0, 1'b1, 1'b0, 4'd15};
`endif
    #2;
    chk("reset_outputs", 32'({vec1, busy1, done1, pass1, err1, ffi1, ffv1}), 0);
    @(posedge clk); #1 rst = 0;
    run(0, e_clean, 49, 0);
    mode = 0;
    run(0, e_zero, 0, 0);
    mode = 2;
    run(0, e_six, 0, 0);
    mode = 1;
    run(0, e_clean, 49, 1);
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    for (int i = 0; i < 200 && vec1 != 4'd9; i++) begin
      @(posedge clk); #1;
    end
    chk("reached_idx9", 32'(vec1), 9);
    #3 rst = 1;
    #1 chk("async_reset_outputs", 32'({vec1, busy1, done1, pass1, err1, ffi1, ffv1}), 0);
    @(posedge clk); #1 rst = 0;
    run(0, e_clean, 49, 0);
    run(1, e_8000, 0, 0);
    repeat (3) @(posedge clk);
    chk("u1_pending", 32'(q1.size()), 0);
    chk("u2_pending", 32'(q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
